// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: Montgomery multiplier state
// encoding, a constant clog2 helper and the default modulus constants
// also used by the modular-exponentiation controller.
package rsa_pkg;

    // Montgomery multiplier sequencing states
    typedef enum logic [1:0] {
        MM_IDLE  = 2'd0,
        MM_CALC  = 2'd1,
        MM_FINAL = 2'd2,
        MM_DONE  = 2'd3
    } mm_state_e;

    // Ceiling log2 for sizing counters at elaboration time
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Default modulus: n = 79, R = 2^7 = 128
    localparam int             N_BIT  = 7;
    localparam logic [N_BIT-1:0] N      = 7'd79;
    localparam logic [N_BIT-1:0] RMODN  = 7'd49;   // 128 mod 79
    localparam logic [N_BIT-1:0] R2MODN = 7'd31;   // 128^2 mod 79

endpackage : rsa_pkg

// File: rtl/mont_mul_r2.sv
// Radix-2 bit-serial Montgomery multiplier: z = x*y*2^-n_bit mod n.
// Responder side of a level start / held done handshake: operands are
// captured when start is seen in IDLE, one multiplier bit is consumed per
// cycle, a single conditional subtraction produces the reduced result, and
// done stays high until the initiator drops start.
module mont_mul_r2
    import rsa_pkg::*;
#(
    parameter int               n_bit = N_BIT,
    parameter logic [n_bit-1:0] n     = N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [n_bit-1:0] x,
    input  logic [n_bit-1:0] y,
    input  logic             start,
    output logic [n_bit-1:0] z,
    output logic             done,
    output logic             busy
);

    localparam int                 cnt_bit  = clog2(n_bit + 1);
    localparam int                 SUM_W    = n_bit + 2;
    localparam logic [cnt_bit-1:0] CNT_LAST = cnt_bit'(n_bit - 1);
    localparam logic [cnt_bit-1:0] CNT_ONE  = cnt_bit'(1);

    mm_state_e          state_q, state_d;
    logic [n_bit-1:0]   xr_q, xr_d;
    logic [n_bit-1:0]   yr_q, yr_d;
    logic [n_bit:0]     a_q, a_d;       // accumulator, always < 2n
    logic [cnt_bit-1:0] cnt_q, cnt_d;
    logic [n_bit-1:0]   z_q, z_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               xi_s;
    logic               q_s;
    logic [SUM_W-1:0]   sum_s;
    logic [n_bit:0]     red_s;

    // Datapath: one Montgomery iteration and the final conditional subtraction
    always_comb begin
        xi_s  = xr_q[cnt_q];
        q_s   = a_q[0] ^ (xi_s & yr_q[0]);
        sum_s = {1'b0, a_q}
              + (xi_s ? {2'b00, yr_q} : {SUM_W{1'b0}})
              + (q_s  ? {2'b00, n}    : {SUM_W{1'b0}});
        if (a_q >= {1'b0, n}) begin
            red_s = a_q - {1'b0, n};
        end else begin
            red_s = a_q;
        end
    end

    // Sequencer: next state and next register values
    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        done_d  = done_q;
        case (state_q)
            MM_IDLE: begin
                if (start) begin
                    xr_d    = x;
                    yr_d    = y;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = MM_CALC;
                end else begin
                    state_d = MM_IDLE;
                end
            end
            MM_CALC: begin
                a_d   = sum_s[SUM_W-1:1];
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = MM_FINAL;
                end else begin
                    state_d = MM_CALC;
                end
            end
            MM_FINAL: begin
                z_d     = red_s[n_bit-1:0];
                done_d  = 1'b1;
                state_d = MM_DONE;
            end
            MM_DONE: begin
                // Held result; only the release of start ends the operation
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = MM_IDLE;
                end else begin
                    state_d = MM_DONE;
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = MM_IDLE;
            end
        endcase
        busy_d = (state_d == MM_CALC) || (state_d == MM_FINAL);
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MM_IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign z    = z_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule : mont_mul_r2
